// File: rtl/mp_add_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mp_add_sequencer_if
// Brief    : Limb-pair input stream and sum-limb output stream of the
//            multi-precision add sequencer. in_sub exists only with MPADD_SUB_EN.
// Revision : 1.0
// ============================================================================
interface mp_add_sequencer_if #(
    parameter int SIZE = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_a;
    logic [SIZE-1:0] in_b;
    logic            in_last;
`ifdef MPADD_SUB_EN
    logic            in_sub;
`endif
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_s;
    logic            out_cout;
    logic            out_last;
    logic            out_err;

`ifdef MPADD_SUB_EN
    modport master (
        output in_valid, in_a, in_b, in_last, in_sub, out_ready,
        input  in_ready, out_valid, out_s, out_cout, out_last, out_err
    );
    modport slave (
        input  in_valid, in_a, in_b, in_last, in_sub, out_ready,
        output in_ready, out_valid, out_s, out_cout, out_last, out_err
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_s, out_cout, out_last, out_err
    );
    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_s, out_cout, out_last, out_err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mp_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mp_add_sequencer (with ripple-carry adder rca)
// Brief    : Adds wide operands one SIZE-bit limb per beat, LS limb first,
//            carrying between limbs. MPADD_SUB_EN adds in_sub (A-B mode).
// Revision : 1.0
// ============================================================================
module rca #(
    parameter int SIZE = 8
) (
    input  wire logic [SIZE-1:0] i_a,
    input  wire logic [SIZE-1:0] i_b,
    input  wire logic            i_cin,
    output logic      [SIZE-1:0] o_s,
    output logic                 o_cout
);
    logic [SIZE:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar i = 0; i < SIZE; i++) begin : g_bit
            assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
            assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    endgenerate

    assign o_cout = w_c[SIZE];
endmodule

module mp_add_sequencer #(
    parameter int SIZE      = 8,
    parameter int MAX_LIMBS = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mp_add_sequencer_if.slave  bus
);
    localparam int c_cnt_w = $clog2(MAX_LIMBS + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_limb_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               r_carry;
    logic               r_out_valid;
    logic [SIZE-1:0]    r_out_s;
    logic               r_out_cout;
    logic               r_out_last;
    logic               r_out_err;

    logic               w_accept;
    logic               w_cnt_full;
    logic               w_pkt_end;
    logic               w_ovf;
    logic               w_sub;
    logic [SIZE-1:0]    w_b;
    logic               w_cin;
    logic [SIZE-1:0]    w_sum;
    logic               w_cout;

`ifdef MPADD_SUB_EN
    assign w_sub = bus.in_sub;
`else
    assign w_sub = 1'b0;
`endif

    assign bus.in_ready = !r_out_valid | bus.out_ready;
    assign w_accept     = bus.in_valid & bus.in_ready;

    assign w_cnt_inc  = r_limb_cnt + 1'b1;
    assign w_cnt_full = (w_cnt_inc == c_cnt_w'(MAX_LIMBS));
    assign w_pkt_end  = bus.in_last | w_cnt_full;
    assign w_ovf      = !bus.in_last & w_cnt_full;

    // Subtraction is A + ~B + 1: the +1 enters as carry-in of the LS limb only.
    assign w_b   = bus.in_b ^ {SIZE{w_sub}};
    assign w_cin = (r_state == IDLE) ? w_sub : r_carry;

    rca #(
        .SIZE (SIZE)
    ) u_rca (
        .i_a    (bus.in_a),
        .i_b    (w_b),
        .i_cin  (w_cin),
        .o_s    (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_limb_cnt;
        if (w_accept) begin
            if (w_pkt_end) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = BUSY;
                w_cnt_nxt   = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_limb_cnt  <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_s     <= '0;
            r_out_cout  <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_limb_cnt <= w_cnt_nxt;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_s     <= w_sum;
                r_out_cout  <= w_cout;
                r_out_last  <= w_pkt_end;
                r_out_err   <= w_ovf;
                r_carry     <= w_pkt_end ? 1'b0 : w_cout;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_s     = r_out_s;
    assign bus.out_cout  = r_out_cout;
    assign bus.out_last  = r_out_last;
    assign bus.out_err   = r_out_err;
endmodule
`default_nettype wire
